pipeline_stall_controller: RTL and testbench
============================================

# pipeline_stall_controller

Central stall/flush sequencer for the five-stage pipeline. Drives the enable and flush inputs of the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards, taken-branch redirects and multi-cycle data-memory waits. It also enforces a memory-wait timeout and keeps saturating stall and flush performance counters.

## Interface
- MEM_TIMEOUT, 16: maximum consecutive cycles with `mem_ready` low before halting; legal range 1 to 2^16-1.
- CNT_W, 32: width of the performance counters.

- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
- id_uses_rs1, id_uses_rs2  in  1 each  ID instruction actually reads rs1 / rs2.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_mem_read  in  1  EX instruction is a load.
- ex_branch_taken  in  1  EX resolved a taken branch or jump; the PC input mux already selects the target.
- mem_req  in  1  MEM-stage instruction accesses data memory this cycle.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register enables; a register captures on CLK when its enable is 1.
- ifid_flush, idex_flush  out  1 each  synchronous clear of IF/ID or ID/EX to a NOP on the next edge; only meaningful when that register's enable is 1.
- mem_timeout  out  1  sticky error; pipeline halted.
- stall_cycles  out  CNT_W  count of cycles with pc_en=0 while not in reset.
- flush_events  out  CNT_W  count of taken-branch redirects.

## Operation
- States:
  - RUN: normal operation.
  - MEM_WAIT: waiting on data memory.
  - HALT: memory timeout; pipeline frozen.
- Outputs are combinational from the state and the current inputs. Priority order: reset > HALT > memory freeze > branch > load-use > normal.
- While RST is high:
  - all enables and flushes are 0.
  - state is RUN, internal wait counter is 0.
  - mem_timeout is 0; both performance counters are 0.
- Memory freeze:
  - Condition: in RUN, `mem_req & ~mem_ready`; or in MEM_WAIT, `~mem_ready`.
  - Response: all five enables 0, both flushes 0.
  - Any branch or load-use condition present is held and is re-evaluated once the freeze releases.
- Branch: ex_branch_taken=1 with no freeze.
  - All enables 1, ifid_flush=1, idex_flush=1.
  - The load-use check is ignored, because the ID instruction is being squashed.
- Load-use:
  - Condition: ex_mem_read & (ex_rd≠0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)), with no freeze and no branch.
  - Response: pc_en=0, ifid_en=0, idex_en=1 with idex_flush=1 (bubble), exmem_en=1, memwb_en=1.
- Normal: all enables 1, flushes 0.
- Transitions:
  - RUN→MEM_WAIT when `mem_req & ~mem_ready`; wait counter loads 1.
  - MEM_WAIT→RUN on the edge after mem_ready=1. In that release cycle the enables are already released and branch/load-use evaluate normally.
  - MEM_WAIT with mem_ready=0: wait counter increments. When the counter equals MEM_TIMEOUT on an edge, the next state is HALT and mem_timeout becomes 1.
  - HALT: all enables and flushes 0; exit only via RST.
- mem_req dropping while in MEM_WAIT is ignored; only mem_ready ends the wait.

## Timing
- Enables and flushes have zero latency: they respond in the same cycle as the inputs.
- Counters, state and mem_timeout update on the rising CLK edge; RST clears them asynchronously.
- stall_cycles increments on every edge where pc_en=0 and RST=0, including HALT cycles. It saturates at all-ones and does not wrap.
- flush_events increments once per cycle in which the branch response is driven. It also saturates.
- A single-cycle load-use bubble produces exactly one stall_cycles increment.
- With mem_ready never asserted, HALT is entered on edge number MEM_TIMEOUT+1, counting from the first frozen cycle. For MEM_TIMEOUT=1, that is the second edge.

## Structure
- Package pipe_ctrl_pkg:
  - state enum RUN=2'b00, MEM_WAIT=2'b01, HALT=2'b10.
  - REG_X0 constant 5'd0.
  - default MEM_TIMEOUT.
- Sub-module load_use_detect: purely combinational comparator producing the load-use hazard bit; instantiated once.
- Top level contains the FSM, the wait counter (width = clog2(MEM_TIMEOUT+1)), output priority logic and both saturating counters.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 for one cycle -> that cycle pc_en=0, ifid_en=0, idex_flush=1; stall_cycles goes 0→1. Repeat with ex_rd=0 -> no stall.
- Branch over load-use: ex_branch_taken=1 with the same load-use inputs -> all enables 1, both flushes 1, flush_events=1, stall_cycles unchanged.
- Memory wait: mem_req=1 and mem_ready=0 for 3 cycles, then mem_ready=1 -> enables 0 for 3 cycles and 1 in the 4th; stall_cycles=3; state back to RUN.
- Branch during wait: ex_branch_taken=1 throughout a 2-cycle wait -> no flush while frozen; flushes asserted in the release cycle; flush_events=1.
- Timeout: MEM_TIMEOUT=4, mem_req=1, mem_ready held 0 -> HALT on edge 5 with mem_timeout=1; a later mem_ready=1 keeps all enables 0. RST pulsed mid-HALT -> state RUN, counters 0.
- Saturation: CNT_W=4 with a continuous load-use stall for 20 cycles -> stall_cycles holds at 15.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline stall controller
// Purpose: sequencer state encoding, architectural zero register, default memory timeout.
// Ports: none (package).
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    HALT     = 2'b10
  } state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

  localparam int unsigned DEFAULT_MEM_TIMEOUT = 16;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard comparator
// Purpose: flags an ID instruction that reads the destination of a load currently in EX.
// Ports:
//   ex_mem_read_i, ex_rd_i           - load in EX and its destination register
//   id_rs1_i, id_rs2_i               - ID source registers
//   id_uses_rs1_i, id_uses_rs2_i     - ID instruction actually reads the source
//   hazard_o                         - load-use hazard present
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rd_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_uses_rs1_i,
  input  logic       id_uses_rs2_i,
  output logic       hazard_o
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = id_uses_rs1_i && (id_rs1_i == ex_rd_i);
  assign rs2_hit  = id_uses_rs2_i && (id_rs2_i == ex_rd_i);
  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign hazard_o = ex_mem_read_i && (ex_rd_i != REG_X0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_stall_controller.sv
// rtl/pipeline_stall_controller.sv - stall/flush sequencer for the five-stage pipeline
// Purpose: drives PC and pipeline-register enables/flushes for load-use, taken-branch
//          and data-memory wait conditions, with a memory-wait timeout and saturating
//          stall/flush performance counters.
// Ports:
//   CLK, RST                          - clock, asynchronous active-high reset
//   id_rs1, id_rs2, id_uses_rs1/rs2   - ID source operands
//   ex_rd, ex_mem_read                - EX destination and load flag
//   ex_branch_taken                   - taken branch/jump resolved in EX
//   mem_req, mem_ready                - data-memory handshake for the MEM stage
//   pc_en ... memwb_en                - register enables
//   ifid_flush, idex_flush            - NOP insertion into IF/ID and ID/EX
//   mem_timeout                       - sticky memory timeout, pipeline halted
//   stall_cycles, flush_events        - saturating performance counters
module pipeline_stall_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int unsigned      WAIT_W      = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(MEM_TIMEOUT);

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic [CNT_W-1:0]   flush_q, flush_d;

  logic load_use;
  logic freeze;
  logic branch_resp;

  load_use_detect u_load_use_detect (
    .ex_mem_read_i (ex_mem_read),
    .ex_rd_i       (ex_rd),
    .id_rs1_i      (id_rs1),
    .id_rs2_i      (id_rs2),
    .id_uses_rs1_i (id_uses_rs1),
    .id_uses_rs2_i (id_uses_rs2),
    .hazard_o      (load_use)
  );

  // Once waiting, only mem_ready ends the wait; a dropped mem_req is ignored.
  always_comb begin
    freeze = 1'b0;
    case (state_q)
      RUN:      freeze = mem_req && !mem_ready;
      MEM_WAIT: freeze = !mem_ready;
      default:  freeze = 1'b0;
    endcase
  end

  // Output priority: reset > halt > memory freeze > branch > load-use > normal.
  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    branch_resp = 1'b0;
    if (RST || state_q == HALT || freeze) begin
      // everything frozen
    end else if (ex_branch_taken) begin
      // The ID instruction is squashed, so any load-use hazard on it is moot.
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      idex_en     = 1'b1;
      exmem_en    = 1'b1;
      memwb_en    = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      branch_resp = 1'b1;
    end else if (load_use) begin
      // Hold PC and IF/ID, push a bubble into ID/EX, let the back end drain.
      idex_en     = 1'b1;
      idex_flush  = 1'b1;
      exmem_en    = 1'b1;
      memwb_en    = 1'b1;
    end else begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      idex_en     = 1'b1;
      exmem_en    = 1'b1;
      memwb_en    = 1'b1;
    end
  end

  // Wait counter holds the number of frozen edges seen so far in this wait;
  // reaching MEM_TIMEOUT while still frozen moves to HALT on the following edge.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    case (state_q)
      RUN: begin
        if (mem_req && !mem_ready) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == TIMEOUT_CNT) begin
          state_d       = HALT;
          mem_timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Performance counters saturate at all-ones instead of wrapping.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!pc_en && stall_q != '1) begin
      stall_d = stall_q + CNT_W'(1);
    end
    if (branch_resp && flush_q != '1) begin
      flush_d = flush_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
      stall_q       <= '0;
      flush_q       <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_q       <= stall_d;
      flush_q       <= flush_d;
    end
  end

  assign mem_timeout  = mem_timeout_q;
  assign stall_cycles = stall_q;
  assign flush_events = flush_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb/tb_pipeline_stall_controller.sv - self-checking bench for pipeline_stall_controller
module tb_pipeline_stall_controller;

  localparam int unsigned TO    = 4;
  localparam int unsigned CW    = 4;
  localparam int          SAT   = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          RST;
  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
  logic          mem_req, mem_ready;
  logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic          ifid_flush, idex_flush, mem_timeout;
  logic [CW-1:0] stall_cycles, flush_events;

  int checks = 0;
  int errors = 0;

  // Reference model: abstract pipeline condition, frozen-edge tally and counters.
  bit m_halted;
  bit m_waiting;
  int m_frozen_edges;
  int m_stalls;
  int m_flushes;

  pipeline_stall_controller #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] ctl_vec();
    return {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush};
  endfunction

  function automatic int sat(input int v);
    return (v > SAT) ? SAT : v;
  endfunction

  // Expected {pc,ifid,idex,exmem,memwb,ifid_flush,idex_flush} from the rules.
  function automatic logic [6:0] model_ctl();
    bit frozen, hazard;
    frozen = m_waiting ? !mem_ready : (mem_req && !mem_ready);
    hazard = ex_mem_read && ex_rd != 0 &&
             ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    if (m_halted || frozen) return 7'b0000000;
    if (ex_branch_taken)    return 7'b1111111;
    if (hazard)             return 7'b0011101;
    return 7'b1111100;
  endfunction

  task automatic model_edge(input logic [6:0] ctl);
    if (ctl[6] == 1'b0) m_stalls++;
    if (ctl[1] && ctl[0] && ctl[6]) m_flushes++;
    if (m_halted) return;
    if (m_waiting) begin
      if (mem_ready) begin
        m_waiting = 0;
      end else begin
        m_frozen_edges++;
        // Halt lands on frozen edge TO+1 counted from the first frozen cycle.
        if (m_frozen_edges == TO + 1) begin
          m_halted  = 1;
          m_waiting = 0;
        end
      end
    end else if (mem_req && !mem_ready) begin
      m_waiting      = 1;
      m_frozen_edges = 1;
    end
  endtask

  task automatic step(input string tag);
    logic [6:0] e;
    #1;
    e = model_ctl();
    chk({tag, "_ctl"}, 32'(ctl_vec()), 32'(e));
    chk({tag, "_stall"}, 32'(stall_cycles), sat(m_stalls));
    chk({tag, "_flush"}, 32'(flush_events), sat(m_flushes));
    chk({tag, "_tmo"}, 32'(mem_timeout), 32'(m_halted));
    @(posedge CLK);
    model_edge(e);
    @(negedge CLK);
  endtask

  task automatic clear_inputs();
    id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_rd = 0; ex_mem_read = 0; ex_branch_taken = 0;
    mem_req = 0; mem_ready = 0;
  endtask

  task automatic do_reset(input string tag);
    RST = 1'b1;
    #1;
    chk({tag, "_rst_ctl"}, 32'(ctl_vec()), 32'h0);
    chk({tag, "_rst_stall"}, 32'(stall_cycles), 32'h0);
    chk({tag, "_rst_flush"}, 32'(flush_events), 32'h0);
    chk({tag, "_rst_tmo"}, 32'(mem_timeout), 32'h0);
    m_halted = 0; m_waiting = 0; m_frozen_edges = 0; m_stalls = 0; m_flushes = 0;
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    ex_mem_read = 1; ex_rd = rd; id_rs1 = 5; id_uses_rs1 = 1;
  endtask

  initial begin
    RST = 1'b1;
    clear_inputs();
    @(negedge CLK);
    do_reset("init");

    // Load-use bubble, then the same with x0 as destination.
    set_load_use(5);
    step("lu");
    chk("lu_stall_after", 32'(stall_cycles), 1);
    set_load_use(0);
    id_rs1 = 0;
    step("lu_x0");
    chk("lu_x0_stall_after", 32'(stall_cycles), 1);

    // Branch overrides load-use.
    set_load_use(5);
    ex_branch_taken = 1;
    step("br_lu");
    chk("br_lu_flush_after", 32'(flush_events), 1);
    chk("br_lu_stall_after", 32'(stall_cycles), 1);
    clear_inputs();

    // Three-cycle memory wait, release, then normal running.
    do_reset("mw");
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) step("mw_wait");
    mem_ready = 1;
    step("mw_rel");
    chk("mw_stall_after", 32'(stall_cycles), 3);
    mem_req = 0;
    step("mw_run");

    // Branch held through a two-cycle wait only redirects on release.
    do_reset("bw");
    mem_req = 1; mem_ready = 0; ex_branch_taken = 1;
    step("bw_wait0");
    step("bw_wait1");
    chk("bw_no_flush_frozen", 32'(flush_events), 0);
    mem_ready = 1;
    step("bw_rel");
    chk("bw_flush_after", 32'(flush_events), 1);
    clear_inputs();

    // Timeout: halt on edge TO+1, mem_ready afterwards does not revive it.
    do_reset("to");
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < TO; i++) step("to_wait");
    chk("to_not_yet", 32'(mem_timeout), 0);
    step("to_edge");
    chk("to_set", 32'(mem_timeout), 1);
    mem_ready = 1;
    step("to_halt_ready");
    chk("to_halt_pc", 32'(pc_en), 0);
    do_reset("to_clear");
    clear_inputs();
    step("to_after_rst");

    // Stall counter saturation.
    do_reset("sat");
    set_load_use(5);
    for (int i = 0; i < 20; i++) step("sat_lu");
    chk("sat_hold", 32'(stall_cycles), SAT);
    clear_inputs();

    // Randomized traffic against the model.
    do_reset("rnd");
    for (int n = 0; n < 400; n++) begin
      if (m_halted && $urandom_range(0, 3) == 0) begin
        do_reset("rnd");
      end
      id_rs1          = 5'($urandom_range(0, 3));
      id_rs2          = 5'($urandom_range(0, 3));
      ex_rd           = 5'($urandom_range(0, 3));
      id_uses_rs1     = 1'($urandom_range(0, 1));
      id_uses_rs2     = 1'($urandom_range(0, 1));
      ex_mem_read     = 1'($urandom_range(0, 1));
      ex_branch_taken = ($urandom_range(0, 4) == 0);
      mem_req         = 1'($urandom_range(0, 1));
      mem_ready       = ($urandom_range(0, 9) < 7);
      step("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
